// File: rtl/uart_fifo_if.sv
// Bus bundle for uart_fifo: pipeline mem_* access, registered read data.
interface uart_fifo_if;
    logic        valid;
    logic        write;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [2:0]  addr;
    logic [31:0] rdata;

    modport master (output valid, write, wmask, wdata, addr, input rdata);
    modport slave  (input valid, write, wmask, wdata, addr, output rdata);
endinterface

// File: rtl/uart_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, programmable divisor, sticky error
// flags and a level interrupt.
module uart_fifo #(
    parameter int CLOCK_RATE = 12_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DIV_WIDTH  = 16,
    parameter int TX_LOG     = 4,
    parameter int RX_LOG     = 4
) (
    input  logic       clk,
    input  logic       rstn,
    uart_fifo_if.slave bus,
    output logic       irq,
    input  logic       uart_rx,
    output logic       uart_tx
);
    localparam int TX_DEPTH = 1 << TX_LOG;
    localparam int RX_DEPTH = 1 << RX_LOG;
    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(CLOCK_RATE / BAUD_RATE);
    localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(4);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [DIV_WIDTH-1:0] r_div;
    logic                 r_rxie, r_txie, r_rxovr, r_ferr, r_txovf;

    logic [7:0]           r_txmem [TX_DEPTH];
    logic [TX_LOG-1:0]    r_txwp, r_txrp;
    logic [TX_LOG:0]      r_txcnt;
    logic [7:0]           r_rxmem [RX_DEPTH];
    logic [RX_LOG-1:0]    r_rxwp, r_rxrp;
    logic [RX_LOG:0]      r_rxcnt;

    logic                 r_tx_busy;
    logic [9:0]           r_tx_sh;
    logic [3:0]           r_tx_bit;
    logic [DIV_WIDTH-1:0] r_tx_cnt, r_tx_div;

    logic                 r_rx_s1, r_rx_s2;
    rx_state_t            r_rx_st;
    logic [2:0]           r_rx_bit;
    logic [7:0]           r_rx_sh;
    logic [DIV_WIDTH-1:0] r_rx_cnt, r_rx_div;

    logic w_rd, w_wr, w_div_wr, w_ctrl_wr, w_clr;
    logic w_tx_full, w_tx_empty, w_tx_req, w_tx_end, w_tx_pop, w_tx_push, w_tx_ovf, w_tx_idle;
    logic w_rx_full, w_rx_empty, w_rx_pop, w_rx_done, w_rx_good, w_rx_push, w_rx_ovr, w_rx_ferr;
    logic [DIV_WIDTH-1:0] w_div_new;
    logic [31:0] w_rdata;
    logic w_unused;

    assign w_rd      = bus.valid & ~bus.write;
    assign w_wr      = bus.valid & bus.write;
    assign w_div_wr  = w_wr & (bus.addr == 3'd2) & (bus.wmask == 4'hF);
    assign w_ctrl_wr = w_wr & (bus.addr == 3'd3) & bus.wmask[0];
    assign w_clr     = w_wr & (bus.addr == 3'd3) & bus.wmask[1] & bus.wdata[8];
    assign w_div_new = (bus.wdata[DIV_WIDTH-1:0] < DIV_MIN) ? DIV_MIN : bus.wdata[DIV_WIDTH-1:0];
    assign w_unused  = ^bus.wdata;

    // A full FIFO holds exactly DEPTH entries, so the count MSB is the full flag.
    assign w_tx_full  = r_txcnt[TX_LOG];
    assign w_tx_empty = (r_txcnt == '0);
    assign w_tx_idle  = w_tx_empty & ~r_tx_busy;
    assign w_tx_req   = w_wr & (bus.addr == 3'd0) & bus.wmask[0];
    assign w_tx_end   = r_tx_busy & (r_tx_cnt == '0) & (r_tx_bit == 4'd9);
    // Reload straight out of the stop bit so back-to-back frames have no gap.
    assign w_tx_pop   = ~w_tx_empty & (~r_tx_busy | w_tx_end);
    assign w_tx_push  = w_tx_req & (~w_tx_full | w_tx_pop);
    assign w_tx_ovf   = w_tx_req & w_tx_full & ~w_tx_pop;

    assign w_rx_full  = r_rxcnt[RX_LOG];
    assign w_rx_empty = (r_rxcnt == '0);
    assign w_rx_pop   = w_rd & (bus.addr == 3'd1) & ~w_rx_empty;
    assign w_rx_done  = (r_rx_st == RX_STOP) & (r_rx_cnt == '0);
    assign w_rx_good  = w_rx_done & r_rx_s2;
    assign w_rx_ferr  = w_rx_done & ~r_rx_s2;
    assign w_rx_push  = w_rx_good & (~w_rx_full | w_rx_pop);
    assign w_rx_ovr   = w_rx_good & w_rx_full & ~w_rx_pop;

    // Register read mux.
    always_comb begin
        w_rdata = 32'hFFFF_FFFF;
        case (bus.addr)
            3'd0: w_rdata = 32'h0;
            3'd1: w_rdata = {w_rx_empty, 23'h0, r_rxmem[r_rxrp]};
            3'd2: w_rdata = 32'(r_div);
            3'd3: w_rdata = {30'h0, r_txie, r_rxie};
            3'd4: w_rdata = {8'h0, 8'(r_txcnt), 8'(r_rxcnt), 2'b0, r_txovf, r_ferr, r_rxovr,
                             w_tx_idle, ~w_rx_empty, ~w_tx_full};
            default: ;
        endcase
    end

    // Bus-side registers: read data, divisor, control, sticky flags, interrupt.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bus.rdata <= 32'h0;
            r_div     <= DIV_RST;
            r_rxie    <= 1'b0;
            r_txie    <= 1'b0;
            r_rxovr   <= 1'b0;
            r_ferr    <= 1'b0;
            r_txovf   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (w_rd) bus.rdata <= w_rdata;
            if (w_div_wr) r_div <= w_div_new;
            if (w_ctrl_wr) begin
                r_rxie <= bus.wdata[0];
                r_txie <= bus.wdata[1];
            end
            // A new error in the clearing cycle survives the clear.
            r_rxovr <= (r_rxovr & ~w_clr) | w_rx_ovr;
            r_ferr  <= (r_ferr  & ~w_clr) | w_rx_ferr;
            r_txovf <= (r_txovf & ~w_clr) | w_tx_ovf;
            irq     <= (r_rxie & ~w_rx_empty) | (r_txie & w_tx_empty);
        end
    end

    // FIFO pointers and occupancy counts.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_txwp <= '0; r_txrp <= '0; r_txcnt <= '0;
            r_rxwp <= '0; r_rxrp <= '0; r_rxcnt <= '0;
        end else begin
            if (w_tx_push) r_txwp <= r_txwp + TX_LOG'(1);
            if (w_tx_pop)  r_txrp <= r_txrp + TX_LOG'(1);
            if (w_tx_push && !w_tx_pop)      r_txcnt <= r_txcnt + (TX_LOG+1)'(1);
            else if (!w_tx_push && w_tx_pop) r_txcnt <= r_txcnt - (TX_LOG+1)'(1);
            if (w_rx_push) r_rxwp <= r_rxwp + RX_LOG'(1);
            if (w_rx_pop)  r_rxrp <= r_rxrp + RX_LOG'(1);
            if (w_rx_push && !w_rx_pop)      r_rxcnt <= r_rxcnt + (RX_LOG+1)'(1);
            else if (!w_rx_push && w_rx_pop) r_rxcnt <= r_rxcnt - (RX_LOG+1)'(1);
        end
    end

    // FIFO storage; contents need no reset since the counts gate every read.
    always_ff @(posedge clk) begin
        if (w_tx_push) r_txmem[r_txwp] <= bus.wdata[7:0];
        if (w_rx_push) r_rxmem[r_rxwp] <= r_rx_sh;
    end

    // TX shifter: divisor is latched per frame, line is re-registered onto uart_tx.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_tx_busy <= 1'b0;
            r_tx_sh   <= '1;
            r_tx_bit  <= '0;
            r_tx_cnt  <= '0;
            r_tx_div  <= DIV_RST;
            uart_tx   <= 1'b1;
        end else begin
            uart_tx <= ~r_tx_busy | r_tx_sh[0];
            if (w_tx_pop) begin
                r_tx_busy <= 1'b1;
                r_tx_sh   <= {1'b1, r_txmem[r_txrp], 1'b0};
                r_tx_bit  <= '0;
                r_tx_cnt  <= r_div - ONE;
                r_tx_div  <= r_div;
            end else if (r_tx_busy) begin
                if (r_tx_cnt == '0) begin
                    if (r_tx_bit == 4'd9) begin
                        r_tx_busy <= 1'b0;
                    end else begin
                        r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
                        r_tx_bit <= r_tx_bit + 4'd1;
                        r_tx_cnt <= r_tx_div - ONE;
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt - ONE;
                end
            end
        end
    end

    // RX synchronizer and frame FSM; samples mid-bit, divisor latched at start.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rx_s1  <= 1'b1;
            r_rx_s2  <= 1'b1;
            r_rx_st  <= RX_IDLE;
            r_rx_bit <= '0;
            r_rx_sh  <= '0;
            r_rx_cnt <= '0;
            r_rx_div <= DIV_RST;
        end else begin
            r_rx_s1 <= uart_rx;
            r_rx_s2 <= r_rx_s1;
            case (r_rx_st)
                RX_IDLE: if (!r_rx_s2) begin
                    r_rx_st  <= RX_START;
                    r_rx_div <= r_div;
                    r_rx_cnt <= (r_div >> 1) - ONE;
                end
                RX_START: if (r_rx_cnt == '0) begin
                    if (r_rx_s2) begin
                        r_rx_st <= RX_IDLE;
                    end else begin
                        r_rx_st  <= RX_DATA;
                        r_rx_bit <= '0;
                        r_rx_cnt <= r_rx_div - ONE;
                    end
                end else r_rx_cnt <= r_rx_cnt - ONE;
                RX_DATA: if (r_rx_cnt == '0) begin
                    r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                    r_rx_bit <= r_rx_bit + 3'd1;
                    r_rx_cnt <= r_rx_div - ONE;
                    if (r_rx_bit == 3'd7) r_rx_st <= RX_STOP;
                end else r_rx_cnt <= r_rx_cnt - ONE;
                RX_STOP: if (r_rx_cnt == '0) r_rx_st <= RX_IDLE;
                         else r_rx_cnt <= r_rx_cnt - ONE;
                default: r_rx_st <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fifo.sv
// Scoreboard bench for uart_fifo: reads and TX frames are checked by monitors.
module tb_uart_fifo;
    localparam int DIV   = 104;
    localparam int FRAME = 10 * DIV;

    logic clk = 1'b0, rstn = 1'b0, irq, uart_rx = 1'b1, uart_tx;
    uart_fifo_if bus();

    uart_fifo #(.CLOCK_RATE(12_000_000), .BAUD_RATE(115200), .DIV_WIDTH(16),
                .TX_LOG(4), .RX_LOG(4)) dut (
        .clk(clk), .rstn(rstn), .bus(bus), .irq(irq), .uart_rx(uart_rx), .uart_tx(uart_tx));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [31:0] exp_val[$], exp_msk[$];
    string       exp_nm[$];
    logic [7:0]  tx_q[$];
    logic        rd_d = 1'b0;
    int unsigned cyc = 0, prev_start = 0;
    bit          tx_chk = 1, contig = 0, have_prev = 0;

    logic [7:0] burst [17] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h10,
                               8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE, 8'h99};
    logic [7:0] rx_tab [16] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h80, 8'h3C, 8'hC3,
                                8'h11, 8'h22, 8'h44, 8'h88, 8'h7E, 8'hE7, 8'h96, 8'h69};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Callers sit on a negedge; each access occupies exactly one cycle.
    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.valid = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wdata = d; bus.wmask = m;
        @(negedge clk);
        bus.valid = 1'b0; bus.write = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, input logic [31:0] v, input logic [31:0] m,
                          input string nm);
        exp_val.push_back(v); exp_msk.push_back(m); exp_nm.push_back(nm);
        bus.valid = 1'b1; bus.write = 1'b0; bus.addr = a;
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopbit);
        uart_rx = 1'b0; idle(DIV);
        for (int i = 0; i < 8; i++) begin uart_rx = b[i]; idle(DIV); end
        uart_rx = stopbit; idle(DIV);
        uart_rx = 1'b1; idle(20);
    endtask

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rd_d <= bus.valid & ~bus.write;
    end

    // Read monitor: rdata is due the cycle after each read.
    always @(negedge clk) begin
        if (rd_d) begin
            if (exp_val.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: got %h want none", bus.rdata);
            end else begin
                logic [31:0] v, m;
                string nm;
                v = exp_val.pop_front(); m = exp_msk.pop_front(); nm = exp_nm.pop_front();
                chk(nm, bus.rdata & m, v & m);
            end
        end
    end

    // TX monitor: decode each frame mid-bit and compare with the expected bytes.
    initial begin
        forever begin
            logic [7:0] b;
            logic s0, s9;
            int unsigned t0;
            @(negedge uart_tx);
            @(negedge clk);
            t0 = cyc;
            if (tx_chk && contig && have_prev) chk("tx_gap", t0 - prev_start, FRAME);
            prev_start = t0; have_prev = 1;
            repeat (DIV/2 - 1) @(negedge clk);
            s0 = uart_tx;
            for (int i = 0; i < 8; i++) begin repeat (DIV) @(negedge clk); b[i] = uart_tx; end
            repeat (DIV) @(negedge clk);
            s9 = uart_tx;
            if (tx_chk) begin
                chk("tx_start_bit", 32'(s0), 32'd0);
                chk("tx_stop_bit", 32'(s9), 32'd1);
                if (tx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected: got %h want none", b);
                end else chk("tx_byte", 32'(b), 32'(tx_q.pop_front()));
            end
        end
    end

    initial begin
        bus.valid = 1'b0; bus.write = 1'b0; bus.addr = 3'd0; bus.wdata = 32'h0; bus.wmask = 4'h0;
        idle(4);
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rdata", bus.rdata, 32'h0);
        rstn = 1'b1; idle(1);
        bus_rd(3'd4, 32'h0000_0005, '1, "rst_status");
        bus_rd(3'd2, 32'd104, '1, "rst_div");
        bus_rd(3'd3, 32'h0, '1, "rst_ctrl");
        bus_rd(3'd5, 32'hFFFF_FFFF, '1, "unmapped_rd");
        bus_rd(3'd0, 32'h0, '1, "txdata_rd");

        // Single frame: line falls two edges after the write edge.
        tx_q.push_back(8'h55);
        bus_wr(3'd0, 32'h55, 4'h1);
        idle(1); chk("tx_fall_early", 32'(uart_tx), 32'd1);
        idle(1); chk("tx_fall_n2", 32'(uart_tx), 32'd0);
        idle(996);
        bus_rd(3'd4, 32'h0000_0001, '1, "tx_busy_status");
        idle(50);
        bus_rd(3'd4, 32'h0000_0005, '1, "tx_idle_status");

        // Overflow burst behind a busy shifter; frames must be back-to-back.
        contig = 1; have_prev = 0;
        tx_q.push_back(8'hC0);
        bus_wr(3'd0, 32'hC0, 4'h1);
        bus_wr(3'd0, 32'h77, 4'hE);
        idle(5);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) tx_q.push_back(burst[i]);
            bus_wr(3'd0, {24'h0, burst[i]}, 4'h1);
        end
        bus_rd(3'd4, 32'h0010_0020, '1, "tx_full_status");
        idle(17 * FRAME + 100);
        contig = 0;
        bus_rd(3'd4, 32'h0000_0025, '1, "tx_drain_status");
        chk("tx_all_sent", tx_q.size(), 32'd0);

        bus_wr(3'd3, 32'h102, 4'h3);
        idle(1); chk("irq_txie", 32'(irq), 32'd1);
        bus_rd(3'd4, 32'h0000_0005, '1, "txovf_cleared");
        bus_rd(3'd3, 32'h0000_0002, '1, "ctrl_readback");
        bus_wr(3'd3, 32'h1, 4'h1);
        idle(1); chk("irq_rx_empty", 32'(irq), 32'd0);

        // Receive path.
        send_rx(8'hA3, 1'b1);
        bus_rd(3'd4, 32'h0000_0107, '1, "rx_one_status");
        chk("irq_rxie", 32'(irq), 32'd1);
        bus_rd(3'd1, 32'h0000_00A3, '1, "rx_a3");
        idle(1); chk("irq_after_pop", 32'(irq), 32'd0);
        bus_rd(3'd1, 32'h8000_0000, 32'hFFFF_FF00, "rx_empty");

        send_rx(8'h5A, 1'b0);
        bus_rd(3'd4, 32'h0000_0015, '1, "ferr_status");
        uart_rx = 1'b0; idle(10); uart_rx = 1'b1; idle(150);
        bus_rd(3'd4, 32'h0000_0015, '1, "glitch_status");
        bus_wr(3'd3, 32'h100, 4'h3);
        bus_rd(3'd4, 32'h0000_0005, '1, "flags_clear");

        for (int i = 0; i < 16; i++) send_rx(rx_tab[i], 1'b1);
        send_rx(8'hEE, 1'b1);
        bus_rd(3'd4, 32'h0000_100F, '1, "rx_ovr_status");
        for (int i = 0; i < 16; i++) bus_rd(3'd1, {24'h0, rx_tab[i]}, '1, "rx_fifo_data");
        bus_rd(3'd1, 32'h8000_0000, 32'hFFFF_FF00, "rx_drained");
        bus_rd(3'd4, 32'h0000_000D, '1, "rxovr_sticky");

        // Divisor writes.
        bus_wr(3'd2, 32'h50, 4'h3);
        bus_rd(3'd2, 32'd104, '1, "div_partial_mask");
        bus_wr(3'd2, 32'd2, 4'hF);
        bus_rd(3'd2, 32'd4, '1, "div_min");
        bus_wr(3'd2, 32'd104, 4'hF);

        // Reset in the middle of a frame.
        tx_chk = 0;
        bus_wr(3'd0, 32'h00, 4'h1);
        bus_wr(3'd0, 32'h11, 4'h1);
        idle(300);
        chk("tx_midframe", 32'(uart_tx), 32'd0);
        rstn = 1'b0; idle(1);
        chk("rst_mid_tx", 32'(uart_tx), 32'd1);
        rstn = 1'b1; idle(1);
        bus_rd(3'd4, 32'h0000_0005, '1, "rst_fifos_empty");
        bus_rd(3'd2, 32'd104, '1, "rst_div_again");
        idle(2);
        chk("rd_queue_empty", exp_val.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
